// File: rtl/triple_des_sched_if.sv
// Request/response bus between the two requesters (plus result consumer) and triple_des_sched.
// The master side drives requests and rsp_ready; the slave side is the scheduler.
interface triple_des_sched_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_data0;
    logic [63:0] req_data1;
    logic [1:0]  req_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_data0, req_data1, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_data0, req_data1, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/triple_des_sched.sv
// Round-robin job scheduler in front of one triple-DES engine: owns the key bank,
// sequences enable/data into the engine, edge-detects done and returns tagged results.
module triple_des_sched #(
    parameter int unsigned ENABLE_HOLD    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 200,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     key_wr_en,
    input  logic [1:0]               key_wr_sel,
    input  logic [63:0]              key_wr_data,
    triple_des_sched_if.slave        bus,
    output logic                     busy,
    output logic                     des_enable,
    output logic                     des_encr_decr,
    output logic [63:0]              des_in,
    output logic [63:0]              des_key1,
    output logic [63:0]              des_key2,
    output logic [63:0]              des_key3,
    input  logic                     des_done,
    input  logic [63:0]              des_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(ENABLE_HOLD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [63:0]       key1_q, key1_d;
    logic [63:0]       key2_q, key2_d;
    logic [63:0]       key3_q, key3_d;
    logic [63:0]       des_in_q, des_in_d;
    logic              encr_q, encr_d;
    logic              enable_q, enable_d;
    logic              id_q, id_d;
    logic [63:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [1:0]        grant;

    // NOTE: every _d starts from its _q so no branch leaves a signal unassigned; that is what keeps this block latch-free.
    always_comb begin
        state_d     = state_q;
        key1_d      = key1_q;
        key2_d      = key2_q;
        key3_d      = key3_q;
        des_in_d    = des_in_q;
        encr_d      = encr_q;
        enable_d    = enable_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        done_d      = des_done;
        grant       = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (key_wr_en) begin
                    case (key_wr_sel)
                        2'd0:    key1_d = key_wr_data;
                        2'd1:    key2_d = key_wr_data;
                        2'd2:    key3_d = key_wr_data;
                        default: ;
                    endcase
                end

                // The pointer only matters, and only moves, when both requesters contend.
                case (bus.req_valid)
                    2'b01:   grant = 2'b01;
                    2'b10:   grant = 2'b10;
                    2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                    default: grant = 2'b00;
                endcase

                if (grant != 2'b00) begin
                    state_d  = ST_LOAD;
                    id_d     = grant[1];
                    des_in_d = grant[1] ? bus.req_data1 : bus.req_data0;
                    encr_d   = grant[1] ? bus.req_mode[1] : bus.req_mode[0];
                    enable_d = 1'b1;
                    cnt_d    = '0;
                    if (bus.req_valid == 2'b11) begin
                        ptr_d = ~grant[1];
                    end
                end
            end

            ST_LOAD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d  = ST_WAIT;
                    enable_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT: begin
                // A done level still high from the previous job has done_q set, so it never counts.
                if (des_done && !done_q) begin
                    state_d     = ST_RESP;
                    rsp_data_d  = des_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the key bank is reset like any other state so des_key* never expose a stale key after reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            key1_q      <= '0;
            key2_q      <= '0;
            key3_q      <= '0;
            des_in_q    <= '0;
            encr_q      <= 1'b0;
            enable_q    <= 1'b0;
            id_q        <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make every flop sample the pre-edge values of its peers.
            state_q     <= state_d;
            key1_q      <= key1_d;
            key2_q      <= key2_d;
            key3_q      <= key3_d;
            des_in_q    <= des_in_d;
            encr_q      <= encr_d;
            enable_q    <= enable_d;
            id_q        <= id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign busy           = (state_q != ST_IDLE);
    assign des_enable     = enable_q;
    assign des_encr_decr  = encr_q;
    assign des_in         = des_in_q;
    assign des_key1       = key1_q;
    assign des_key2       = key2_q;
    assign des_key3       = key3_q;

endmodule

// File: tb/tb_triple_des_sched.sv
// Self-checking bench for triple_des_sched: a stub engine, a transaction-level model of
// grants and responses checked every cycle, and directed scenarios with literal expectations.
module tb_triple_des_sched;

    localparam int H = 2;
    localparam int T = 40;
    localparam int L = 5;

    localparam logic [63:0] KEY = 64'h736865726c6f636b;
    localparam logic [63:0] PT  = 64'h5368656C6C73686F;
    localparam logic [63:0] CT  = 64'h81C28058B7764C21;
    localparam logic [63:0] ALT = 64'h0123456789ABCDEF;

    typedef struct {
        logic        id;
        logic [63:0] data;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [63:0] data;
        logic        mode;
    } job_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        key_wr_en = 1'b0;
    logic [1:0]  key_wr_sel = 2'd0;
    logic [63:0] key_wr_data = 64'h0;
    logic        busy;
    logic        des_enable;
    logic        des_encr_decr;
    logic [63:0] des_in;
    logic [63:0] des_key1;
    logic [63:0] des_key2;
    logic [63:0] des_key3;
    logic        des_done = 1'b0;
    logic [63:0] des_out = 64'h0;

    triple_des_sched_if bus ();

    triple_des_sched #(
        .ENABLE_HOLD    (H),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (8)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .key_wr_en     (key_wr_en),
        .key_wr_sel    (key_wr_sel),
        .key_wr_data   (key_wr_data),
        .bus           (bus),
        .busy          (busy),
        .des_enable    (des_enable),
        .des_encr_decr (des_encr_decr),
        .des_in        (des_in),
        .des_key1      (des_key1),
        .des_key2      (des_key2),
        .des_key3      (des_key3),
        .des_done      (des_done),
        .des_out       (des_out)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: the known-answer pair for the all-same key, an invertible mix otherwise.
    function automatic logic [63:0] engine_fn(input logic [63:0] d, input logic enc,
                                              input logic [63:0] k1, input logic [63:0] k2,
                                              input logic [63:0] k3);
        if (k1 == KEY && k2 == KEY && k3 == KEY && enc && d == PT) return CT;
        if (k1 == KEY && k2 == KEY && k3 == KEY && !enc && d == CT) return PT;
        return enc ? (((d ^ k1) + k2) ^ k3) : (((d ^ k3) - k2) ^ k1);
    endfunction

    // Engine stub: done rises eng_lat cycles after the last sampled enable and stays high.
    logic eng_dead = 1'b0;
    int   eng_lat  = L;
    int   eng_cd   = 0;

    always @(posedge clk) begin
        if (!eng_dead) begin
            if (des_enable) begin
                eng_cd   <= eng_lat;
                des_done <= 1'b0;
            end else if (eng_cd != 0) begin
                eng_cd <= eng_cd - 1;
                if (eng_cd == 1) begin
                    des_done <= 1'b1;
                    des_out  <= engine_fn(des_in, des_encr_decr, des_key1, des_key2, des_key3);
                end
            end
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Requester drivers: each holds its head job valid until accepted.
    job_t       rq0[$];
    job_t       rq1[$];
    logic [1:0] acc = 2'b00;

    always @(negedge clk) acc = bus.req_ready & bus.req_valid;

    always @(posedge clk) begin
        #1;
        if (acc[0] && rq0.size() != 0) void'(rq0.pop_front());
        if (acc[1] && rq1.size() != 0) void'(rq1.pop_front());
        bus.req_valid[0] = (rq0.size() != 0);
        bus.req_valid[1] = (rq1.size() != 0);
        bus.req_data0    = (rq0.size() != 0) ? rq0[0].data : 64'h0;
        bus.req_data1    = (rq1.size() != 0) ? rq1[0].data : 64'h0;
        bus.req_mode[0]  = (rq0.size() != 0) ? rq0[0].mode : 1'b0;
        bus.req_mode[1]  = (rq1.size() != 0) ? rq1[0].mode : 1'b0;
    end

    // Transaction model: at most one job in flight; grants only while nothing is outstanding.
    logic [63:0] sk1 = 64'h0;
    logic [63:0] sk2 = 64'h0;
    logic [63:0] sk3 = 64'h0;
    logic        ptr_m = 1'b0;
    rsp_t        exp_q[$];
    rsp_t        rsp_log[$];
    rsp_t        last_rsp;
    logic        gnt_log[$];
    int          cyc = 0;
    int          gnt_cyc = 0;
    int          last_lat = 0;
    int          rsp_cnt = 0;
    int          en_run = 0;
    logic        seen_valid = 1'b0;

    always @(negedge clk) begin
        logic [1:0]  exp_gnt;
        logic        gid;
        logic [63:0] gdata;
        logic        gmode;
        cyc++;
        if (nrst) begin
            exp_gnt = 2'b00;
            if (exp_q.size() == 0) begin
                case (bus.req_valid)
                    2'b01:   exp_gnt = 2'b01;
                    2'b10:   exp_gnt = 2'b10;
                    2'b11:   exp_gnt = ptr_m ? 2'b10 : 2'b01;
                    default: exp_gnt = 2'b00;
                endcase
            end
            check("req_ready", 64'(bus.req_ready), 64'(exp_gnt));
            if (exp_gnt != 2'b00) begin
                gid = exp_gnt[1];
                if (bus.req_valid == 2'b11) ptr_m = ~gid;
                gdata = gid ? bus.req_data1 : bus.req_data0;
                gmode = bus.req_mode[gid];
                exp_q.push_back('{id: gid,
                                  data: eng_dead ? 64'h0 : engine_fn(gdata, gmode, sk1, sk2, sk3),
                                  err: eng_dead});
                gnt_log.push_back(gid);
                gnt_cyc    = cyc;
                seen_valid = 1'b0;
            end
            if (bus.rsp_valid && exp_q.size() == 0) begin
                check("rsp_spurious", 64'(bus.rsp_valid), 64'(0));
            end else if (bus.rsp_valid) begin
                if (!seen_valid) begin
                    last_lat   = cyc - gnt_cyc;
                    seen_valid = 1'b1;
                end
                check("rsp_id", 64'(bus.rsp_id), 64'(exp_q[0].id));
                check("rsp_data", bus.rsp_data, exp_q[0].data);
                check("rsp_err", 64'(bus.rsp_err), 64'(exp_q[0].err));
                if (bus.rsp_ready) begin
                    last_rsp = '{id: bus.rsp_id, data: bus.rsp_data, err: bus.rsp_err};
                    rsp_log.push_back(last_rsp);
                    void'(exp_q.pop_front());
                    rsp_cnt++;
                end
            end
            if (des_enable) begin
                en_run++;
            end else if (en_run != 0) begin
                check("enable_hold", 64'(en_run), 64'(H));
                en_run = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_key(input logic [1:0] sel, input logic [63:0] val, input bit take);
        key_wr_en   = 1'b1;
        key_wr_sel  = sel;
        key_wr_data = val;
        tick(1);
        key_wr_en = 1'b0;
        if (take) begin
            case (sel)
                2'd0:    sk1 = val;
                2'd1:    sk2 = val;
                2'd2:    sk3 = val;
                default: ;
            endcase
        end
    endtask

    task automatic load_keys();
        write_key(2'd0, KEY, 1'b1);
        write_key(2'd1, KEY, 1'b1);
        write_key(2'd2, KEY, 1'b1);
    endtask

    task automatic wait_rsps(input int target);
        int n = 0;
        while (rsp_cnt < target && n < 600) begin
            tick(1);
            n++;
        end
        check("rsp_wait", 64'(rsp_cnt), 64'(target));
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_data", bus.rsp_data, 64'h0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_des_enable", 64'(des_enable), 64'(0));
        check("rst_des_encr_decr", 64'(des_encr_decr), 64'(0));
        check("rst_des_in", des_in, 64'h0);
        check("rst_keys", des_key1 | des_key2 | des_key3, 64'h0);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        ptr_m      = 1'b0;
        sk1        = 64'h0;
        sk2        = 64'h0;
        sk3        = 64'h0;
        en_run     = 0;
        seen_valid = 1'b0;
        tick(2);
        nrst = 1'b1;
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        bus.req_valid = 2'b00;
        bus.req_data0 = 64'h0;
        bus.req_data1 = 64'h0;
        bus.req_mode  = 2'b00;
        bus.rsp_ready = 1'b1;
        #2;
        do_reset();

        // Encrypt known-answer vector on requester 0.
        load_keys();
        check("key1", des_key1, KEY);
        check("key2", des_key2, KEY);
        check("key3", des_key3, KEY);
        write_key(2'd3, ALT, 1'b0);
        check("key_sel3_k1", des_key1, KEY);
        check("key_sel3_k3", des_key3, KEY);
        rq0.push_back('{data: PT, mode: 1'b1});
        wait_rsps(1);
        check("enc_id", 64'(last_rsp.id), 64'(0));
        check("enc_data", last_rsp.data, CT);
        check("enc_err", 64'(last_rsp.err), 64'(0));
        check("enc_latency", 64'(last_lat), 64'(H + L + 2));

        // Decrypt on requester 1.
        rq1.push_back('{data: CT, mode: 1'b0});
        wait_rsps(2);
        check("dec_id", 64'(last_rsp.id), 64'(1));
        check("dec_data", last_rsp.data, PT);
        check("dec_err", 64'(last_rsp.err), 64'(0));

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        load_keys();
        gnt_log.delete();
        rsp_log.delete();
        base = rsp_cnt;
        rq0.push_back('{data: PT, mode: 1'b1});
        rq0.push_back('{data: ALT, mode: 1'b0});
        rq1.push_back('{data: CT, mode: 1'b0});
        rq1.push_back('{data: ALT, mode: 1'b1});
        wait_rsps(base + 4);
        check("rr_count", 64'(gnt_log.size()), 64'(4));
        if (gnt_log.size() >= 4 && rsp_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr_grant%0d", i), 64'(gnt_log[i]), 64'(i % 2));
                check($sformatf("rr_rsp_id%0d", i), 64'(rsp_log[i].id), 64'(i % 2));
            end
            check("rr_data0", rsp_log[0].data, CT);
            check("rr_data1", rsp_log[1].data, PT);
        end

        // Timeout: engine silent, done left high from the previous job.
        eng_dead = 1'b1;
        base = rsp_cnt;
        rq0.push_back('{data: ALT, mode: 1'b1});
        wait_rsps(base + 1);
        check("to_err", 64'(last_rsp.err), 64'(1));
        check("to_data", last_rsp.data, 64'h0);
        check("to_latency", 64'(last_lat), 64'(H + T + 1));
        check("to_busy_clear", 64'(busy), 64'(0));
        eng_dead = 1'b0;

        // Backpressure: response held while rsp_ready is low; key write in RESP dropped.
        bus.rsp_ready = 1'b0;
        base = rsp_cnt;
        rq1.push_back('{data: ALT, mode: 1'b1});
        for (int i = 0; i < 100 && !bus.rsp_valid; i++) tick(1);
        check("hold_valid_seen", 64'(bus.rsp_valid), 64'(1));
        write_key(2'd0, ~KEY, 1'b0);
        tick(8);
        check("hold_valid", 64'(bus.rsp_valid), 64'(1));
        check("hold_id", 64'(bus.rsp_id), 64'(1));
        check("hold_data", bus.rsp_data, engine_fn(ALT, 1'b1, KEY, KEY, KEY));
        check("hold_key_dropped", des_key1, KEY);
        bus.rsp_ready = 1'b1;
        wait_rsps(base + 1);

        // Reset while waiting on the engine: no response, then a clean job.
        eng_lat = 30;
        rq0.push_back('{data: PT, mode: 1'b1});
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (busy && !des_enable) break;
        end
        tick(3);
        check("pre_reset_busy", 64'(busy), 64'(1));
        base = rsp_cnt;
        do_reset();
        eng_lat = L;
        tick(40);
        check("no_rsp_after_reset", 64'(rsp_cnt), 64'(base));
        load_keys();
        rq0.push_back('{data: PT, mode: 1'b1});
        wait_rsps(base + 1);
        check("post_reset_id", 64'(last_rsp.id), 64'(0));
        check("post_reset_data", last_rsp.data, CT);
        check("post_reset_err", 64'(last_rsp.err), 64'(0));

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
